// File: rtl/booth_mult.sv
// booth_mult: sequential radix-2 Booth multiplier, signed WIDTH x WIDTH -> 2*WIDTH.
// One operation in flight. Operands are latched when Start is accepted in IDLE;
// Hi/Lo hold the previous product until the new one is transferred.
//
// state | meaning
// IDLE  | waiting for Start; Busy=0, Done=0
// RUN   | WIDTH Booth steps, then one cycle that transfers {acc,q} to Hi/Lo
// DONE  | Done=1 for exactly one cycle, then back to IDLE unconditionally
//
// RUN lasts WIDTH+1 cycles: cnt counts 0..WIDTH-1 while stepping, and the
// cycle with cnt==WIDTH copies the finished product into Hi/Lo. Together with
// one IDLE and one DONE cycle, this gives 35 cycles per operation at WIDTH=32.

module booth_mult #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH:0]   m_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] q_q;
    logic             q1_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   sum_d;
    logic [WIDTH:0]   acc_d;
    logic [WIDTH-1:0] q_d;
    logic             q1_d;

    // One Booth step: conditional add/subtract of M, then arithmetic shift of {acc,q,q_1}.
    always_comb begin
        sum_d = acc_q;
        case ({q_q[0], q1_q})
            2'b01:   sum_d = acc_q + m_q;
            2'b10:   sum_d = acc_q - m_q;
            default: sum_d = acc_q;
        endcase
        acc_d = {sum_d[WIDTH], sum_d[WIDTH:1]};
        q_d   = {sum_d[0], q_q[WIDTH-1:1]};
        q1_d  = q_q[0];
    end

    // Sequencing FSM with the datapath registers and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (Start) begin
                        m_q     <= {A[WIDTH-1], A};
                        acc_q   <= '0;
                        q_q     <= B;
                        q1_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        // acc[WIDTH] only duplicates the sign here, so the low
                        // WIDTH bits of acc are the upper product word.
                        hi_q    <= acc_q[WIDTH-1:0];
                        lo_q    <= q_q;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        acc_q <= acc_d;
                        q_q   <= q_d;
                        q1_q  <= q1_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Hi   = hi_q;
    assign Lo   = lo_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_booth_mult.sv
// Directed bench for booth_mult: hand-computed products, latency, Busy/Done
// framing, ignored requests, reset mid-operation and back-to-back operation.

module tb_booth_mult;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Done;

    int checks = 0;
    int errors = 0;

    booth_mult #(.WIDTH(32), .CNT_W(6)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Hi    (Hi),
        .Lo    (Lo),
        .Busy  (Busy),
        .Done  (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present operands with Start at a falling edge; returns #1 after the accepting edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        A     = a;
        B     = b;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    // Full operation: latency, Busy framing, result, single Done pulse.
    task automatic full_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        int busy_cnt;
        start_op(a, b);
        cyc      = 0;
        busy_cnt = Busy ? 1 : 0;
        while (!Done && cyc < 100) begin
            @(posedge Clk);
            #1;
            cyc++;
            if (Busy) busy_cnt++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd33);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        chk({tag, "_busy_at_done"}, 64'(Busy), 64'd0);
        chk({tag, "_hi"}, 64'(Hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(Lo), 64'(exp_lo));
        @(posedge Clk);
        #1;
        chk({tag, "_done_single"}, 64'(Done), 64'd0);
    endtask

    initial begin
        int ndone;
        int viol;
        int cyc;
        int last;
        logic [31:0] lo_at_done;
        logic [31:0] hi_at_done;

        Reset = 1'b1;
        Start = 1'b1;
        A     = 32'h5;
        B     = 32'h6;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_outputs", {Hi, Lo}, 64'd0);
        chk("reset_flags", {62'd0, Busy, Done}, 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        Start = 1'b0;

        full_op("3x4", 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C);
        full_op("m1x5", 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        full_op("7x0", 32'd7, 32'd0, 32'h0, 32'h0);
        full_op("min_min", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        full_op("max_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
        full_op("min_max", 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 32'h8000_0000);

        // 6x7 with a second request and scrambled operands during RUN.
        start_op(32'd6, 32'd7);
        ndone      = 0;
        viol       = 0;
        lo_at_done = '0;
        hi_at_done = '1;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Done) begin
                ndone++;
                lo_at_done = Lo;
                hi_at_done = Hi;
            end else if (Busy && (Hi !== 32'hC000_0000 || Lo !== 32'h8000_0000)) begin
                viol++;
            end
            if (i == 0) begin
                A = 32'd9;
                B = 32'd9;
            end else begin
                A = $urandom;
                B = $urandom;
            end
            Start = (i < 3);
        end
        Start = 1'b0;
        chk("ignore_done_count", 64'(ndone), 64'd1);
        chk("ignore_lo", 64'(lo_at_done), 64'd42);
        chk("ignore_hi", 64'(hi_at_done), 64'd0);
        chk("hold_during_run", 64'(viol), 64'd0);

        // Reset in the middle of an operation discards it.
        full_op("2x3", 32'd2, 32'd3, 32'h0, 32'h6);
        start_op(32'd5, 32'd5);
        repeat (9) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("midreset_result", {Hi, Lo}, 64'd0);
        chk("midreset_flags", {62'd0, Busy, Done}, 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        ndone = 0;
        viol  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Done) ndone++;
            if (Busy) viol++;
        end
        chk("midreset_no_done", 64'(ndone), 64'd0);
        chk("midreset_no_busy", 64'(viol), 64'd0);
        full_op("5x5", 32'd5, 32'd5, 32'h0, 32'd25);

        // Start held high: one result every 35 cycles.
        @(negedge Clk);
        A     = 32'd2;
        B     = 32'hFFFF_FFFD;
        Start = 1'b1;
        cyc   = 0;
        ndone = 0;
        last  = -1;
        while (ndone < 3 && cyc < 200) begin
            @(posedge Clk);
            #1;
            cyc++;
            if (Done) begin
                chk("b2b_result", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFA);
                if (last >= 0) chk("b2b_period", 64'(cyc - last), 64'd35);
                last = cyc;
                ndone++;
            end
        end
        Start = 1'b0;
        chk("b2b_done_count", 64'(ndone), 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
